ann_input_loader: RTL and testbench
===================================

// Module: ann_input_loader
// PURPOSE
//  Sequences the 11-bit input FIFO stream after a load_kdtree trigger.
//  Phase order is internal nodes, then leaf patches, then query patches.
//  Packs the words and issues single-cycle writes to node, leaf, leaf-index and query memories.
//  Sits between in_fifo (FWFT) and the accelerator memories; the search FSM starts only after query_done.
// PARAMETERS
//  DATA_WIDTH   11   width of one stream word
//  PATCH_SIZE   5    data words per patch
//  LEAF_SIZE    8    patches per leaf
//  NUM_LEAVES   64   leaves; NUM_NODES = NUM_LEAVES-1 internal nodes
//  NUM_QUERYS   512  query patches (ROW_SIZE 32 x COL_SIZE 16)
// PORTS
//  io_clk          in   1    sole clock
//  io_rst          in   1    synchronous, active-high reset
//  load_kdtree     in   1    start pulse; sampled only in IDLE
//  in_fifo_rempty_n in  1    FIFO head valid
//  in_fifo_rdata   in   11   FIFO head word
//  in_fifo_deq     out  1    pop head; = rempty_n & state in {NODE,LEAF,QUERY}
//  node_wen        out  1    node write strobe
//  node_waddr      out  6    node index 0..62
//  node_wdata      out  22   {median[10:0], 8'b0, index[2:0]}
//  leaf_wen        out  1    leaf patch + index write strobe
//  leaf_waddr      out  9    {leaf_id[5:0], slot[2:0]}
//  leaf_wdata      out  55   patch words, word k at [11k +: 11]
//  leaf_idx_wdata  out  11   patch origin index (6th word)
//  query_wen       out  1    query write strobe
//  query_waddr     out  9    query patch 0..511
//  query_wdata     out  55   word k at [11k +: 11]
//  load_done       out  1    level: tree loaded
//  query_done      out  1    level: queries loaded
//  busy            out  1    state != IDLE && state != DONE
// BEHAVIOUR
//  Reset: state=IDLE; all counters and pack register 0; every output 0.
//  States: IDLE -load_kdtree-> NODE -126 words-> LEAF -3072 words-> QUERY -2560 words-> DONE.
//  DONE returns to NODE on load_kdtree. That trigger clears load_done and query_done in the same cycle.
//  load_kdtree in NODE/LEAF/QUERY: ignored; no restart, no error.
//  Word accept: a word is accepted on a cycle where in_fifo_deq=1.
//  FIFO empty: nothing is consumed and no counter moves; back-pressure can occur on any word.
//  NODE: even word -> index = rdata[2:0]. Odd word -> median.
//    A write is issued on the registered next cycle; node_waddr = pair count.
//  LEAF: words 0..4 of each 6-word group are packed.
//    Word 5 is the index; it triggers leaf_wen next cycle.
//    slot wraps 7->0 and increments leaf_id; leaf_id 63 slot 7 completes the phase.
//  QUERY: every 5th accepted word triggers query_wen next cycle; query_waddr increments, max 511.
//  Write latency: exactly 1 cycle after the last word of the unit is accepted.
//    Strobes are 1-cycle pulses; addr and data are held stable only while the strobe is high.
//  Phase end: the final write of NODE and LEAF issues in the same cycle as the first accept of the next phase.
//    Counters are per-phase, so there is no conflict.
//  load_done rises with the last leaf_wen; query_done rises with the last query_wen.
//  Counter widths fit maxima exactly: word-in-unit 3b, slot 3b, leaf 6b, node 6b, query 9b.
//  There is no saturation; the phase exits at terminal count.
//  Reset mid-operation: abort; a partial patch is discarded; the FIFO is not flushed.
// CONFIGURATION
//  ANN_LOADER_CHECKSUM_EN defined:
//    Adds output csum[15:0] = running 16-bit sum (mod 2^16) of every accepted word since load_kdtree.
//    load_kdtree zeroes the sum.
//    Also adds output csum_valid, which rises with query_done.
//  Not defined: the ports are absent and there is no added logic.
// STRUCTURE
//  ann_loader_pkg:
//    State enum (IDLE,NODE,LEAF,QUERY,DONE).
//    Width constants: NODE_W=22, PATCH_W=DATA_WIDTH*PATCH_SIZE, LEAF_AW, QUERY_AW.
//    Phase word totals: NODE_WORDS=126, LEAF_WORDS=3072, QUERY_WORDS=2560.
//  Sub-module ann_patch_packer: word counter plus PATCH_W shift/insert register.
//    Shared by the LEAF and QUERY phases; clear is asserted on every phase entry.
// TESTING
//  1. Reset, then load_kdtree, then stream 0..125 with no gaps.
//     -> 63 node_wen; node 0 = {11'd1, 11'd0}; node 62 = {11'd125, 11'd4}.
//  2. Leaf phase, word value = i.
//     -> leaf_waddr 0: data words 0..4, idx 5.
//     -> leaf_waddr 511 last: idx = 3071 mod 2048 = 1023. load_done=1 after that write.
//  3. Query phase, word value = i.
//     -> query_waddr 0 data {4,3,2,1,0}; 512 writes total.
//     -> query_done=1, busy=0, state DONE.
//  4. rempty_n toggling randomly at 50% through all phases.
//     -> identical memory image to test 3; deq never high while rempty_n=0.
//  5. io_rst=1 mid-leaf (3 words into a patch).
//     -> all outputs 0 next cycle, no leaf_wen.
//     -> a new load_kdtree restarts at node 0.
//  6. load_kdtree pulsed during QUERY -> ignored.
//     The same pulse in DONE -> load_done/query_done clear and node phase restarts.
//     With checksum enabled, csum=0 on restart.

Source files
------------

// File: rtl/ann_loader_pkg.sv
// Shared types and sizing for the ANN input loader.
// Tree geometry is fixed: 63 nodes, 64 leaves of 8 patches, 512 queries.
package ann_loader_pkg;

    localparam int DATA_WIDTH = 11;
    localparam int PATCH_SIZE = 5;
    localparam int LEAF_SIZE  = 8;
    localparam int NUM_LEAVES = 64;
    localparam int NUM_NODES  = NUM_LEAVES - 1;
    localparam int NUM_QUERYS = 512;

    localparam int NODE_W   = 22;
    localparam int PATCH_W  = DATA_WIDTH * PATCH_SIZE;
    localparam int NODE_AW  = 6;
    localparam int LEAF_AW  = 9;
    localparam int QUERY_AW = 9;

    localparam int NODE_WORDS  = 2 * NUM_NODES;
    localparam int LEAF_WORDS  = NUM_LEAVES * LEAF_SIZE * (PATCH_SIZE + 1);
    localparam int QUERY_WORDS = NUM_QUERYS * PATCH_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        NODE,
        LEAF,
        QUERY,
        DONE
    } state_t;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/ann_input_loader_if.sv
// FIFO read side plus node/leaf/query memory write ports.
// master = loader, slave = FIFO and memories.
interface ann_input_loader_if
    import ann_loader_pkg::*;
;
    logic                in_fifo_rempty_n;
    word_t               in_fifo_rdata;
    logic                in_fifo_deq;
    logic                node_wen;
    logic [NODE_AW-1:0]  node_waddr;
    logic [NODE_W-1:0]   node_wdata;
    logic                leaf_wen;
    logic [LEAF_AW-1:0]  leaf_waddr;
    logic [PATCH_W-1:0]  leaf_wdata;
    word_t               leaf_idx_wdata;
    logic                query_wen;
    logic [QUERY_AW-1:0] query_waddr;
    logic [PATCH_W-1:0]  query_wdata;

    modport master (
        input  in_fifo_rempty_n, in_fifo_rdata,
        output in_fifo_deq,
        output node_wen, node_waddr, node_wdata,
        output leaf_wen, leaf_waddr, leaf_wdata, leaf_idx_wdata,
        output query_wen, query_waddr, query_wdata
    );

    modport slave (
        output in_fifo_rempty_n, in_fifo_rdata,
        input  in_fifo_deq,
        input  node_wen, node_waddr, node_wdata,
        input  leaf_wen, leaf_waddr, leaf_wdata, leaf_idx_wdata,
        input  query_wen, query_waddr, query_wdata
    );

endinterface

// File: rtl/ann_patch_packer.sv
// Word counter and patch assembly register shared by LEAF and QUERY.
// patch is the register merged with the word accepted this cycle.
module ann_patch_packer
    import ann_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [2:0]         last,
    input  word_t              data,
    output logic               done,
    output logic [PATCH_W-1:0] patch
);

    logic [2:0]         cnt;
    logic [PATCH_W-1:0] pack;

    assign done = accept && (cnt == last);

    // Positions past the patch (the leaf index word) are not packed.
    always_comb begin
        patch = pack;
        if (accept && cnt < 3'(PATCH_SIZE))
            patch[DATA_WIDTH*int'(cnt) +: DATA_WIDTH] = data;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            pack <= '0;
        end else if (accept) begin
            if (done) begin
                cnt  <= '0;
                pack <= '0;
            end else begin
                cnt  <= cnt + 3'd1;
                pack <= patch;
            end
        end
    end

endmodule

// File: rtl/ann_input_loader.sv
// Streams tree nodes, leaf patches and query patches from in_fifo into memories.
// Define ANN_LOADER_CHECKSUM_EN to add the csum/csum_valid outputs.
module ann_input_loader
    import ann_loader_pkg::*;
(
    input  logic io_clk,
    input  logic io_rst,
    input  logic load_kdtree,
    ann_input_loader_if.master bus,
    output logic load_done,
    output logic query_done,
    output logic busy
`ifdef ANN_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] csum,
    output logic        csum_valid
`endif
);

    state_t state, state_nx;

    logic                accept, trigger, odd;
    logic [NODE_AW-1:0]  pair;
    logic [2:0]          node_idx;
    logic [2:0]          slot;
    logic [5:0]          leaf_id;
    logic [QUERY_AW-1:0] query_cnt;
    logic                node_last, leaf_last, query_last;
    logic                pk_accept, pk_clear, pk_done;
    logic [2:0]          pk_last;
    logic [PATCH_W-1:0]  pk_patch;

    always_ff @(posedge io_clk) begin
        if (io_rst) state <= IDLE;
        else        state <= state_nx;
    end

    assign node_last  = accept && state == NODE && odd
                        && pair == NODE_AW'(NUM_NODES - 1);
    assign leaf_last  = pk_done && state == LEAF && {leaf_id, slot} == '1;
    assign query_last = pk_done && state == QUERY && query_cnt == '1;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (load_kdtree) state_nx = NODE;
            NODE:    if (node_last)   state_nx = LEAF;
            LEAF:    if (leaf_last)   state_nx = QUERY;
            QUERY:   if (query_last)  state_nx = DONE;
            DONE:    if (load_kdtree) state_nx = NODE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        accept    = bus.in_fifo_rempty_n
                    && (state == NODE || state == LEAF || state == QUERY);
        busy      = state != IDLE && state != DONE;
        trigger   = load_kdtree && (state == IDLE || state == DONE);
        pk_accept = accept && (state == LEAF || state == QUERY);
        pk_last   = (state == LEAF) ? 3'(PATCH_SIZE) : 3'(PATCH_SIZE - 1);
    end

    assign pk_clear        = state_nx != state;
    assign bus.in_fifo_deq = accept;

    ann_patch_packer u_packer (
        .clk    (io_clk),
        .rst    (io_rst),
        .clear  (pk_clear),
        .accept (pk_accept),
        .last   (pk_last),
        .data   (bus.in_fifo_rdata),
        .done   (pk_done),
        .patch  (pk_patch)
    );

    // Even word carries the split index, odd word the median.
    always_ff @(posedge io_clk) begin
        if (io_rst || trigger) begin
            odd            <= 1'b0;
            pair           <= '0;
            node_idx       <= '0;
            bus.node_wen   <= 1'b0;
            bus.node_waddr <= '0;
            bus.node_wdata <= '0;
        end else begin
            bus.node_wen <= 1'b0;
            if (state == NODE && accept) begin
                odd <= !odd;
                if (!odd) begin
                    node_idx <= bus.in_fifo_rdata[2:0];
                end else begin
                    bus.node_wen   <= 1'b1;
                    bus.node_waddr <= pair;
                    bus.node_wdata <= {bus.in_fifo_rdata, 8'b0, node_idx};
                    pair           <= pair + NODE_AW'(1);
                end
            end
        end
    end

    always_ff @(posedge io_clk) begin
        if (io_rst || trigger) begin
            slot               <= '0;
            leaf_id            <= '0;
            load_done          <= 1'b0;
            bus.leaf_wen       <= 1'b0;
            bus.leaf_waddr     <= '0;
            bus.leaf_wdata     <= '0;
            bus.leaf_idx_wdata <= '0;
        end else begin
            bus.leaf_wen <= 1'b0;
            if (state == LEAF && pk_done) begin
                bus.leaf_wen       <= 1'b1;
                bus.leaf_waddr     <= {leaf_id, slot};
                bus.leaf_wdata     <= pk_patch;
                bus.leaf_idx_wdata <= bus.in_fifo_rdata;
                {leaf_id, slot}    <= {leaf_id, slot} + 9'd1;
                if (leaf_last) load_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge io_clk) begin
        if (io_rst || trigger) begin
            query_cnt       <= '0;
            query_done      <= 1'b0;
            bus.query_wen   <= 1'b0;
            bus.query_waddr <= '0;
            bus.query_wdata <= '0;
        end else begin
            bus.query_wen <= 1'b0;
            if (state == QUERY && pk_done) begin
                bus.query_wen   <= 1'b1;
                bus.query_waddr <= query_cnt;
                bus.query_wdata <= pk_patch;
                query_cnt       <= query_cnt + QUERY_AW'(1);
                if (query_last) query_done <= 1'b1;
            end
        end
    end

`ifdef ANN_LOADER_CHECKSUM_EN
    always_ff @(posedge io_clk) begin
        if (io_rst || trigger) csum <= '0;
        else if (accept)       csum <= csum + 16'(bus.in_fifo_rdata);
    end

    assign csum_valid = query_done;
`endif

endmodule

// File: tb/tb_ann_input_loader.sv
// Random-gap stream bench for ann_input_loader against a word-index model.
// Covers node/leaf/query images, mid-leaf reset and load_kdtree retriggers.
module tb_ann_input_loader;
    import ann_loader_pkg::*;

    localparam int TOTAL = NODE_WORDS + LEAF_WORDS + QUERY_WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kick = 1'b0;
    logic load_done, query_done, busy;
`ifdef ANN_LOADER_CHECKSUM_EN
    logic [15:0] csum;
    logic        csum_valid;
`endif

    always #5 clk = ~clk;

    ann_input_loader_if bus ();

    ann_input_loader dut (
        .io_clk      (clk),
        .io_rst      (rst),
        .load_kdtree (kick),
        .bus         (bus),
        .load_done   (load_done),
        .query_done  (query_done),
        .busy        (busy)
`ifdef ANN_LOADER_CHECKSUM_EN
        ,
        .csum        (csum),
        .csum_valid  (csum_valid)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model
    int  fifo[$];
    bit  gaps = 1'b0;
    bit  pop  = 1'b0;

    always @(posedge clk) begin
        #1;
        if (pop) void'(fifo.pop_front());
        bus.in_fifo_rempty_n = (fifo.size() > 0)
                               && (!gaps || $urandom_range(1) == 1);
        bus.in_fifo_rdata = (fifo.size() > 0) ? 11'(fifo[0]) : 11'd0;
    end

    // Reference model: every accepted word is indexed from the trigger.
    logic [10:0]      acc_w [TOTAL];
    bit               m_active = 0, m_ld = 0, m_qd = 0;
    int               m_n = 0;
    logic [15:0]      m_csum = '0;
    bit               e_node_wen = 0, e_leaf_wen = 0, e_query_wen = 0;
    logic [5:0]       e_node_addr;
    logic [21:0]      e_node_data;
    logic [8:0]       e_leaf_addr, e_query_addr;
    logic [54:0]      e_leaf_data, e_query_data;
    logic [10:0]      e_leaf_idx;

    // Captured memory images
    logic [21:0] node_mem [64];
    logic [54:0] leaf_mem [512];
    logic [10:0] idx_mem [512];
    logic [54:0] query_mem [512];
    int n_node = 0, n_leaf = 0, n_query = 0;
    int first_node = -1;

    function automatic logic [54:0] pack5(int base);
        logic [54:0] p;
        for (int k = 0; k < 5; k++) p[11*k +: 11] = acc_w[base+k];
        return p;
    endfunction

    always @(negedge clk) begin
        bit was_active;
        bit acc;
        logic [10:0] w;
        int i, j;
        check("deq", bus.in_fifo_deq, bus.in_fifo_rempty_n && m_active);
        check("busy", busy, m_active);
        check("node_wen", bus.node_wen, e_node_wen);
        if (e_node_wen) begin
            check("node_waddr", bus.node_waddr, e_node_addr);
            check("node_wdata", bus.node_wdata, e_node_data);
        end
        check("leaf_wen", bus.leaf_wen, e_leaf_wen);
        if (e_leaf_wen) begin
            check("leaf_waddr", bus.leaf_waddr, e_leaf_addr);
            check("leaf_wdata", bus.leaf_wdata, e_leaf_data);
            check("leaf_idx", bus.leaf_idx_wdata, e_leaf_idx);
        end
        check("query_wen", bus.query_wen, e_query_wen);
        if (e_query_wen) begin
            check("query_waddr", bus.query_waddr, e_query_addr);
            check("query_wdata", bus.query_wdata, e_query_data);
        end
        check("load_done", load_done, m_ld);
        check("query_done", query_done, m_qd);
`ifdef ANN_LOADER_CHECKSUM_EN
        check("csum", csum, m_csum);
        check("csum_valid", csum_valid, m_qd);
`endif
        if (bus.node_wen) begin
            if (n_node == 0) first_node = int'(bus.node_waddr);
            node_mem[bus.node_waddr] = bus.node_wdata;
            n_node++;
        end
        if (bus.leaf_wen) begin
            leaf_mem[bus.leaf_waddr] = bus.leaf_wdata;
            idx_mem[bus.leaf_waddr]  = bus.leaf_idx_wdata;
            n_leaf++;
        end
        if (bus.query_wen) begin
            query_mem[bus.query_waddr] = bus.query_wdata;
            n_query++;
        end

        pop = bus.in_fifo_rempty_n && bus.in_fifo_deq;
        was_active = m_active;
        acc = bus.in_fifo_rempty_n && m_active;
        w = bus.in_fifo_rdata;
        e_node_wen = 0;
        e_leaf_wen = 0;
        e_query_wen = 0;
        if (rst) begin
            m_active = 0;
            m_n = 0;
            m_ld = 0;
            m_qd = 0;
            m_csum = '0;
        end else begin
            if (acc) begin
                i = m_n;
                acc_w[i] = w;
                m_n++;
                m_csum = m_csum + 16'(w);
                if (i < NODE_WORDS) begin
                    if (i % 2 == 1) begin
                        e_node_wen  = 1;
                        e_node_addr = 6'(i / 2);
                        e_node_data = {w, 8'b0, acc_w[i-1][2:0]};
                    end
                end else if (i < NODE_WORDS + LEAF_WORDS) begin
                    j = i - NODE_WORDS;
                    if (j % 6 == 5) begin
                        e_leaf_wen  = 1;
                        e_leaf_addr = 9'(j / 6);
                        e_leaf_data = pack5(i - 5);
                        e_leaf_idx  = w;
                        if (j / 6 == 511) m_ld = 1;
                    end
                end else begin
                    j = i - NODE_WORDS - LEAF_WORDS;
                    if (j % 5 == 4) begin
                        e_query_wen  = 1;
                        e_query_addr = 9'(j / 5);
                        e_query_data = pack5(i - 4);
                        if (j / 5 == 511) m_qd = 1;
                    end
                end
                if (m_n == TOTAL) m_active = 0;
            end
            if (kick && !was_active) begin
                m_active = 1;
                m_n = 0;
                m_ld = 0;
                m_qd = 0;
                m_csum = '0;
            end
        end
    end

    task automatic push_stream();
        for (int i = 0; i < NODE_WORDS; i++) fifo.push_back(i);
        for (int i = 0; i < LEAF_WORDS; i++) fifo.push_back(i % 2048);
        for (int i = 0; i < QUERY_WORDS; i++) fifo.push_back(i % 2048);
    endtask

    task automatic pulse_kick();
        @(posedge clk);
        #2 kick = 1'b1;
        @(posedge clk);
        #2 kick = 1'b0;
    endtask

    task automatic wait_qd(int budget);
        int c = 0;
        while (!query_done && c < budget) begin
            @(posedge clk);
            c++;
        end
        #2;
        check("query_done_timeout", query_done, 1'b1);
    endtask

    task automatic clear_counts();
        n_node = 0;
        n_leaf = 0;
        n_query = 0;
        first_node = -1;
    endtask

    logic [21:0] node_ref [64];
    logic [54:0] leaf_ref [512];
    logic [10:0] idx_ref [512];
    logic [54:0] query_ref [512];

    initial begin
        int c;
        bus.in_fifo_rempty_n = 1'b0;
        bus.in_fifo_rdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_deq", bus.in_fifo_deq, 0);
        check("rst_node_wen", bus.node_wen, 0);
        check("rst_node_waddr", bus.node_waddr, 0);
        check("rst_node_wdata", bus.node_wdata, 0);
        check("rst_leaf_wen", bus.leaf_wen, 0);
        check("rst_leaf_waddr", bus.leaf_waddr, 0);
        check("rst_leaf_wdata", bus.leaf_wdata, 0);
        check("rst_leaf_idx", bus.leaf_idx_wdata, 0);
        check("rst_query_wen", bus.query_wen, 0);
        check("rst_query_waddr", bus.query_waddr, 0);
        check("rst_query_wdata", bus.query_wdata, 0);
        check("rst_flags", {load_done, query_done, busy}, 0);
        rst = 1'b0;

        // Gap-free full load
        clear_counts();
        push_stream();
        pulse_kick();
        wait_qd(20000);
        repeat (2) @(posedge clk);
        #2;
        check("n_node", n_node, 63);
        check("n_leaf", n_leaf, 512);
        check("n_query", n_query, 512);
        check("node0", node_mem[0], {11'd1, 11'd0});
        check("node62", node_mem[62], {11'd125, 11'd4});
        check("leaf0", leaf_mem[0], {11'd4, 11'd3, 11'd2, 11'd1, 11'd0});
        check("idx0", idx_mem[0], 5);
        check("leaf511",leaf_mem[511],
              {11'd1022, 11'd1021, 11'd1020, 11'd1019, 11'd1018});
        check("idx511", idx_mem[511], 1023);
        check("query0", query_mem[0], {11'd4, 11'd3, 11'd2, 11'd1, 11'd0});
        check("query511", query_mem[511],
              {11'd511, 11'd510, 11'd509, 11'd508, 11'd507});
        check("done_flags", {load_done, query_done, busy}, 3'b110);
        node_ref = node_mem;
        leaf_ref = leaf_mem;
        idx_ref = idx_mem;
        query_ref = query_mem;

        // Random back-pressure, retrigger from DONE
        clear_counts();
        gaps = 1'b1;
        push_stream();
        pulse_kick();
        wait_qd(40000);
        gaps = 1'b0;
        check("gap_n_node", n_node, 63);
        check("gap_n_leaf", n_leaf, 512);
        check("gap_n_query", n_query, 512);
        for (int k = 0; k < 63; k++)
            check("gap_node_img", node_mem[k], node_ref[k]);
        for (int k = 0; k < 512; k++) begin
            check("gap_leaf_img", leaf_mem[k], leaf_ref[k]);
            check("gap_idx_img", idx_mem[k], idx_ref[k]);
            check("gap_query_img", query_mem[k], query_ref[k]);
        end

        // Reset three words into the third leaf patch
        clear_counts();
        for (int i = 0; i < NODE_WORDS + 6 * 2 + 3; i++) fifo.push_back(i);
        pulse_kick();
        c = 0;
        while (fifo.size() > 0 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        check("drain_timeout", fifo.size(), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check("mid_rst_leaf_wen", bus.leaf_wen, 0);
        check("mid_rst_outs",
              {bus.in_fifo_deq, bus.node_wen, bus.query_wen,
               load_done, query_done, busy}, 0);
        check("mid_rst_addrs",
              {bus.node_waddr, bus.leaf_waddr, bus.query_waddr}, 0);
        check("mid_rst_leaf_data", bus.leaf_wdata, 0);
        check("mid_rst_n_leaf", n_leaf, 2);
        fifo.delete();
        clear_counts();
        push_stream();
        pulse_kick();
        wait_qd(20000);
        check("restart_node", first_node, 0);
        check("restart_n_leaf", n_leaf, 512);

        // Trigger in QUERY ignored, trigger in DONE restarts
        clear_counts();
        push_stream();
        pulse_kick();
        repeat (NODE_WORDS + LEAF_WORDS + 100) @(posedge clk);
        #2;
        check("in_query", {busy, load_done, query_done}, 3'b110);
        pulse_kick();
        check("q_kick_busy", busy, 1);
        wait_qd(20000);
        check("q_kick_n_query", n_query, 512);
        check("q_kick_n_node", n_node, 63);
        pulse_kick();
        check("done_kick_flags", {load_done, query_done, busy}, 3'b001);
`ifdef ANN_LOADER_CHECKSUM_EN
        check("done_kick_csum", csum, 0);
`endif
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
